// File: rtl/alu_issue_decode.sv
// alu_issue_decode: RV32I decode/issue stage driving ALU controls through one registered valid/ready slot.
module alu_issue_decode #(
   parameter int XLEN  = 32,
   parameter int RADDR = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       aluoper,
   output logic             selopr2,
   output logic [XLEN-1:0]  dataimmed,
   output logic [RADDR-1:0] rs1addr,
   output logic [RADDR-1:0] rs2addr,
   output logic [RADDR-1:0] rdaddr,
   output logic             regwrite,
   output logic             branch,
   output logic             illegal
);
   localparam int BW = 4 + 1 + XLEN + 3 * RADDR + 3;
   localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd5, SRL = 4'd6, SRA = 4'd7, SLT = 4'd8, SLTU = 4'd9;

   logic [2:0]       f3;
   logic [6:0]       f7;
   logic [XLEN-1:0]  imm_i, imm_s, imm_b;
   logic [3:0]       a_op;
   logic             a_sel, a_wr, a_br, a_ill, accept;
   logic [XLEN-1:0]  a_imm;
   logic [RADDR-1:0] a_rs1, a_rs2, a_rd;
   logic [BW-1:0]    bundle_d, bundle_q;
   logic             out_valid_d, out_valid_q;

   function automatic logic [3:0] f3_op(input logic [2:0] f);
      case (f)
         3'b000:  return ADD;
         3'b001:  return SLL;
         3'b010:  return SLT;
         3'b011:  return SLTU;
         3'b100:  return 4'd4;
         3'b101:  return SRL;
         3'b110:  return 4'd3;
         default: return 4'd2;
      endcase
   endfunction

   assign f3    = instr[14:12];
   assign f7    = instr[31:25];
   assign imm_i = {{20{instr[31]}}, instr[31:20]};
   assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

   always_comb begin
      a_op  = ADD;
      a_sel = 1'b0;
      a_imm = '0;
      a_rs1 = instr[19:15];
      a_rs2 = instr[24:20];
      a_rd  = instr[11:7];
      a_wr  = 1'b0;
      a_br  = 1'b0;
      a_ill = 1'b0;
      case (instr[6:0])
         7'b0110011: begin
            a_wr = 1'b1;
            if (f7 == 7'b0000000) a_op = f3_op(f3);
            else if (f7 == 7'b0100000 && f3 == 3'b000) a_op = SUB;
            else if (f7 == 7'b0100000 && f3 == 3'b101) a_op = SRA;
            else a_ill = 1'b1;
         end
         7'b0010011: begin
            a_sel = 1'b1;
            a_wr  = 1'b1;
            a_rs2 = '0;
            a_op  = f3_op(f3);
            a_imm = imm_i;
            // Shifts carry a zero-extended shamt and use funct7 to pick SRL/SRA
            if (f3 == 3'b001 || f3 == 3'b101) begin
               a_imm = {27'b0, instr[24:20]};
               a_op  = f3 == 3'b001 ? SLL : f7[5] ? SRA : SRL;
               a_ill = !(f7 == 7'b0000000 || (f3 == 3'b101 && f7 == 7'b0100000));
            end
         end
         7'b0110111: begin
            a_sel = 1'b1;
            a_rs1 = '0;
            a_imm = {instr[31:12], 12'b0};
            a_wr  = 1'b1;
         end
         7'b0000011: begin
            a_sel = 1'b1;
            a_imm = imm_i;
            a_wr  = 1'b1;
         end
         7'b0100011: begin
            a_sel = 1'b1;
            a_imm = imm_s;
         end
         7'b1100011: begin
            a_br  = 1'b1;
            a_imm = imm_b;
            a_op  = !f3[2] ? SUB : f3[1] ? SLTU : SLT;
            a_ill = f3[2:1] == 2'b01;
         end
         default: a_ill = 1'b1;
      endcase
      if (a_ill) begin
         a_op = ADD;
         a_wr = 1'b0;
         a_br = 1'b0;
      end
      if (a_rd == '0) a_wr = 1'b0;
   end

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      out_valid_d = !flush && (accept || (out_valid_q && !out_ready));
      bundle_d    = (accept && !flush) ? {a_op, a_sel, a_imm, a_rs1, a_rs2, a_rd, a_wr, a_br, a_ill} : bundle_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         bundle_q    <= bundle_d;
      end
   end

   assign out_valid = out_valid_q;
   assign {aluoper, selopr2, dataimmed, rs1addr, rs2addr, rdaddr, regwrite, branch, illegal} = bundle_q;
endmodule
